// File: rtl/dma_pkg.sv
// Arbiter state encodings and master indices for the DMA/BFM front end.
package dma_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } arb_wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } arb_rd_state_e;

  localparam int unsigned ARB_M_DMA = 0;
  localparam int unsigned ARB_M_BFM = 1;

  // One-hot grant codes derived from the master indices.
  localparam logic [1:0] ARB_GNT_DMA = 2'(1 << ARB_M_DMA);
  localparam logic [1:0] ARB_GNT_BFM = 2'(1 << ARB_M_BFM);

endpackage

// File: rtl/venus_soc_pkg.sv
// SoC-level AXI4 request/response bundles shared by DMA, BFM and memory wrappers.
package venus_soc_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 512;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  // Master-to-slave direction: AW, W, AR payloads plus B/R readies.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  b_ready;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  r_ready;
  } axi_req_t;

  // Slave-to-master direction: AW/W/AR readies plus B and R payloads.
  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_arb_rr2.sv
// Two-way arbiter with a one-bit last-winner pointer.
// AXI_ARB_FIXED_PRIO_EN: DMA always wins a tie and the pointer is removed.
module axi_arb_rr2
  import dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant_c
);

`ifdef AXI_ARB_FIXED_PRIO_EN

  // Fixed priority: DMA first, BFM only when DMA is not requesting.
  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req[0])      grant_c = ARB_GNT_DMA;
      else if (req[1]) grant_c = ARB_GNT_BFM;
    end
  end

`else

  logic last_bfm_q;

  // Round-robin: on a tie the master that did not win last time is chosen.
  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant_c = ARB_GNT_DMA;
        2'b10:   grant_c = ARB_GNT_BFM;
        2'b11:   grant_c = last_bfm_q ? ARB_GNT_DMA : ARB_GNT_BFM;
        default: grant_c = 2'b00;
      endcase
    end
  end

  // Pointer resets to "BFM last" and moves in the cycle a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_bfm_q <= 1'b1;
    end else if (grant_c != 2'b00) begin
      last_bfm_q <= (grant_c == ARB_GNT_BFM);
    end
  end

`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// DMA/BFM to single-slave AXI4 arbiter; read and write locked per transaction.
// AXI_ARB_FIXED_PRIO_EN selects fixed DMA priority instead of round-robin.
module axi_master_arbiter
  import venus_soc_pkg::*;
  import dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  axi_req_t   axi_req_i_dma,
  output axi_resp_t  axi_resp_o_dma,
  input  axi_req_t   axi_req_i_bfm,
  output axi_resp_t  axi_resp_o_bfm,
  output axi_req_t   axi_req_o,
  input  axi_resp_t  axi_resp_i,
  output logic [1:0] wr_grant_o,
  output logic [1:0] rd_grant_o
);

  localparam axi_req_t  REQ_ZERO  = '0;
  localparam axi_resp_t RESP_ZERO = '0;

  arb_wr_state_e w_state_q, w_state_d;
  arb_rd_state_e r_state_q, r_state_d;
  logic [1:0]    wr_grant_q, wr_grant_d;
  logic [1:0]    rd_grant_q, rd_grant_d;
  logic [1:0]    wr_arb_grant_c, rd_arb_grant_c;
  logic          wr_arb_en_c, rd_arb_en_c;
  axi_req_t      w_mreq_c, r_mreq_c;
  axi_req_t      fwd_w_c, fwd_r_c;
  axi_resp_t     rsp_w_c, rsp_r_c;

  assign wr_arb_en_c = (w_state_q == W_IDLE);
  assign rd_arb_en_c = (r_state_q == R_IDLE);

  axi_arb_rr2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({axi_req_i_bfm.aw_valid, axi_req_i_dma.aw_valid}),
    .en      (wr_arb_en_c),
    .grant_c (wr_arb_grant_c)
  );

  axi_arb_rr2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({axi_req_i_bfm.ar_valid, axi_req_i_dma.ar_valid}),
    .en      (rd_arb_en_c),
    .grant_c (rd_arb_grant_c)
  );

  // Owner's request bundle per direction.
  assign w_mreq_c = (wr_grant_q == ARB_GNT_BFM) ? axi_req_i_bfm : axi_req_i_dma;
  assign r_mreq_c = (rd_grant_q == ARB_GNT_BFM) ? axi_req_i_bfm : axi_req_i_dma;

  // State and grant registers for both directions.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wr_grant_q <= 2'b00;
      rd_grant_q <= 2'b00;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
    end
  end

  // Write FSM: grant in idle, then AW, W burst, B, back to idle.
  always_comb begin
    w_state_d  = w_state_q;
    wr_grant_d = wr_grant_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_arb_grant_c != 2'b00) begin
          wr_grant_d = wr_arb_grant_c;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: if (w_mreq_c.aw_valid && axi_resp_i.aw_ready) w_state_d = W_DATA;
      W_DATA: if (w_mreq_c.w_valid && axi_resp_i.w_ready && w_mreq_c.w_last) w_state_d = W_RESP;
      W_RESP: begin
        if (axi_resp_i.b_valid && w_mreq_c.b_ready) begin
          w_state_d  = W_IDLE;
          wr_grant_d = 2'b00;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        wr_grant_d = 2'b00;
      end
    endcase
  end

  // Read FSM: grant in idle, then AR, R burst, back to idle.
  always_comb begin
    r_state_d  = r_state_q;
    rd_grant_d = rd_grant_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_arb_grant_c != 2'b00) begin
          rd_grant_d = rd_arb_grant_c;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: if (r_mreq_c.ar_valid && axi_resp_i.ar_ready) r_state_d = R_DATA;
      R_DATA: begin
        if (axi_resp_i.r_valid && r_mreq_c.r_ready && axi_resp_i.r_last) begin
          r_state_d  = R_IDLE;
          rd_grant_d = 2'b00;
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        rd_grant_d = 2'b00;
      end
    endcase
  end

  // Write-side routing: each channel is passed only in its forwarding state.
  always_comb begin
    fwd_w_c = REQ_ZERO;
    rsp_w_c = RESP_ZERO;
    case (w_state_q)
      W_ADDR: begin
        fwd_w_c.aw_id    = w_mreq_c.aw_id;
        fwd_w_c.aw_addr  = w_mreq_c.aw_addr;
        fwd_w_c.aw_len   = w_mreq_c.aw_len;
        fwd_w_c.aw_size  = w_mreq_c.aw_size;
        fwd_w_c.aw_burst = w_mreq_c.aw_burst;
        fwd_w_c.aw_valid = w_mreq_c.aw_valid;
        rsp_w_c.aw_ready = axi_resp_i.aw_ready;
      end
      W_DATA: begin
        fwd_w_c.w_data  = w_mreq_c.w_data;
        fwd_w_c.w_strb  = w_mreq_c.w_strb;
        fwd_w_c.w_last  = w_mreq_c.w_last;
        fwd_w_c.w_valid = w_mreq_c.w_valid;
        rsp_w_c.w_ready = axi_resp_i.w_ready;
      end
      W_RESP: begin
        fwd_w_c.b_ready = w_mreq_c.b_ready;
        rsp_w_c.b_id    = axi_resp_i.b_id;
        rsp_w_c.b_resp  = axi_resp_i.b_resp;
        rsp_w_c.b_valid = axi_resp_i.b_valid;
      end
      default: ;
    endcase
  end

  // Read-side routing: each channel is passed only in its forwarding state.
  always_comb begin
    fwd_r_c = REQ_ZERO;
    rsp_r_c = RESP_ZERO;
    case (r_state_q)
      R_ADDR: begin
        fwd_r_c.ar_id    = r_mreq_c.ar_id;
        fwd_r_c.ar_addr  = r_mreq_c.ar_addr;
        fwd_r_c.ar_len   = r_mreq_c.ar_len;
        fwd_r_c.ar_size  = r_mreq_c.ar_size;
        fwd_r_c.ar_burst = r_mreq_c.ar_burst;
        fwd_r_c.ar_valid = r_mreq_c.ar_valid;
        rsp_r_c.ar_ready = axi_resp_i.ar_ready;
      end
      R_DATA: begin
        fwd_r_c.r_ready = r_mreq_c.r_ready;
        rsp_r_c.r_id    = axi_resp_i.r_id;
        rsp_r_c.r_data  = axi_resp_i.r_data;
        rsp_r_c.r_resp  = axi_resp_i.r_resp;
        rsp_r_c.r_last  = axi_resp_i.r_last;
        rsp_r_c.r_valid = axi_resp_i.r_valid;
      end
      default: ;
    endcase
  end

  // Read and write fields are disjoint, so the two directions merge by OR.
  assign axi_req_o      = axi_req_t'(fwd_w_c | fwd_r_c);
  assign axi_resp_o_dma = axi_resp_t'(((wr_grant_q == ARB_GNT_DMA) ? rsp_w_c : RESP_ZERO) |
                                      ((rd_grant_q == ARB_GNT_DMA) ? rsp_r_c : RESP_ZERO));
  assign axi_resp_o_bfm = axi_resp_t'(((wr_grant_q == ARB_GNT_BFM) ? rsp_w_c : RESP_ZERO) |
                                      ((rd_grant_q == ARB_GNT_BFM) ? rsp_r_c : RESP_ZERO));
  assign wr_grant_o     = wr_grant_q;
  assign rd_grant_o     = rd_grant_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: directed lock/fairness/reset scenarios followed
// by randomized traffic, all checked every cycle against a transaction-level model.
module tb_axi_master_arbiter;
  import venus_soc_pkg::*;

  localparam logic [511:0] PAT1 = {16{32'hDEAD_0001}};
  localparam logic [511:0] PAT2 = {16{32'h1234_5678}};
  localparam int IDLE = 0, ADDR = 1, DATA = 2, RESP = 3;

  logic       clk = 1'b0;
  logic       rst;
  axi_req_t   req_dma, req_bfm, req_o;
  axi_resp_t  rsp_dma, rsp_bfm, rsp_i;
  logic [1:0] wg, rg;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner (-1 none, 0 DMA, 1 BFM), phase and last winner per direction.
  int w_own = -1, w_ph = IDLE, w_last = 1;
  int r_own = -1, r_ph = IDLE, r_last = 1;

  axi_req_t   e_req;
  axi_resp_t  e_rsp [2];
  logic [1:0] e_wg, e_rg;

  always #5 clk = ~clk;

  axi_master_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .axi_req_i_dma  (req_dma),
    .axi_resp_o_dma (rsp_dma),
    .axi_req_i_bfm  (req_bfm),
    .axi_resp_o_bfm (rsp_bfm),
    .axi_req_o      (req_o),
    .axi_resp_i     (rsp_i),
    .wr_grant_o     (wg),
    .rd_grant_o     (rg)
  );

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_req(input string nm, input axi_req_t act, input axi_req_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input axi_resp_t act, input axi_resp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] rand_bits();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Arbitration rule: sole requester wins; on a tie the one that did not win last.
  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 1) ? 0 : 1;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Expected outputs from the model state and the current inputs.
  task automatic model_outputs();
    axi_req_t m [2];
    m[0] = req_dma;
    m[1] = req_bfm;
    e_req    = '0;
    e_rsp[0] = '0;
    e_rsp[1] = '0;
    e_wg = (w_own < 0) ? 2'b00 : 2'(1 << w_own);
    e_rg = (r_own < 0) ? 2'b00 : 2'(1 << r_own);
    if (w_own >= 0 && w_ph == ADDR) begin
      e_req.aw_id    = m[w_own].aw_id;
      e_req.aw_addr  = m[w_own].aw_addr;
      e_req.aw_len   = m[w_own].aw_len;
      e_req.aw_size  = m[w_own].aw_size;
      e_req.aw_burst = m[w_own].aw_burst;
      e_req.aw_valid = m[w_own].aw_valid;
      e_rsp[w_own].aw_ready = rsp_i.aw_ready;
    end
    if (w_own >= 0 && w_ph == DATA) begin
      e_req.w_data  = m[w_own].w_data;
      e_req.w_strb  = m[w_own].w_strb;
      e_req.w_last  = m[w_own].w_last;
      e_req.w_valid = m[w_own].w_valid;
      e_rsp[w_own].w_ready = rsp_i.w_ready;
    end
    if (w_own >= 0 && w_ph == RESP) begin
      e_req.b_ready = m[w_own].b_ready;
      e_rsp[w_own].b_id    = rsp_i.b_id;
      e_rsp[w_own].b_resp  = rsp_i.b_resp;
      e_rsp[w_own].b_valid = rsp_i.b_valid;
    end
    if (r_own >= 0 && r_ph == ADDR) begin
      e_req.ar_id    = m[r_own].ar_id;
      e_req.ar_addr  = m[r_own].ar_addr;
      e_req.ar_len   = m[r_own].ar_len;
      e_req.ar_size  = m[r_own].ar_size;
      e_req.ar_burst = m[r_own].ar_burst;
      e_req.ar_valid = m[r_own].ar_valid;
      e_rsp[r_own].ar_ready = rsp_i.ar_ready;
    end
    if (r_own >= 0 && r_ph == DATA) begin
      e_req.r_ready = m[r_own].r_ready;
      e_rsp[r_own].r_id    = rsp_i.r_id;
      e_rsp[r_own].r_data  = rsp_i.r_data;
      e_rsp[r_own].r_resp  = rsp_i.r_resp;
      e_rsp[r_own].r_last  = rsp_i.r_last;
      e_rsp[r_own].r_valid = rsp_i.r_valid;
    end
  endtask

  // Advance the transaction model by one clock edge.
  task automatic model_step();
    axi_req_t m [2];
    int win;
    m[0] = req_dma;
    m[1] = req_bfm;
    if (rst) begin
      w_own = -1; w_ph = IDLE; w_last = 1;
      r_own = -1; r_ph = IDLE; r_last = 1;
      return;
    end
    if (w_ph == IDLE) begin
      win = pick(m[0].aw_valid, m[1].aw_valid, w_last);
      if (win >= 0) begin w_own = win; w_last = win; w_ph = ADDR; end
    end else if (w_ph == ADDR) begin
      if (m[w_own].aw_valid && rsp_i.aw_ready) w_ph = DATA;
    end else if (w_ph == DATA) begin
      if (m[w_own].w_valid && rsp_i.w_ready && m[w_own].w_last) w_ph = RESP;
    end else begin
      if (rsp_i.b_valid && m[w_own].b_ready) begin w_own = -1; w_ph = IDLE; end
    end
    if (r_ph == IDLE) begin
      win = pick(m[0].ar_valid, m[1].ar_valid, r_last);
      if (win >= 0) begin r_own = win; r_last = win; r_ph = ADDR; end
    end else if (r_ph == ADDR) begin
      if (m[r_own].ar_valid && rsp_i.ar_ready) r_ph = DATA;
    end else begin
      if (rsp_i.r_valid && m[r_own].r_ready && rsp_i.r_last) begin r_own = -1; r_ph = IDLE; end
    end
  endtask

  // Compare process: check all outputs late in each cycle, then step the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      model_outputs();
      chk_req("axi_req_o", req_o, e_req);
      chk_rsp("resp_dma", rsp_dma, e_rsp[0]);
      chk_rsp("resp_bfm", rsp_bfm, e_rsp[1]);
      chk64("wr_grant", 64'(wg), 64'(e_wg));
      chk64("rd_grant", 64'(rg), 64'(e_rg));
      @(posedge clk);
      model_step();
    end
  end

  // Stimulus: directed scenarios with literal checks, then random traffic.
  initial begin
    logic [1023:0] rb;
    rst = 1'b1;
    req_dma = '0;
    req_bfm = '0;
    rsp_i   = '0;
    repeat (2) @(negedge clk);
    #3;
    chk64("rst_wr_grant", 64'(wg), 64'd0);
    chk64("rst_rd_grant", 64'(rg), 64'd0);
    chk_req("rst_req_o", req_o, '0);

    // Both masters raise AW together right after reset.
    @(negedge clk);
    rst = 1'b0;
    req_dma.aw_valid = 1'b1; req_dma.aw_addr = 32'h1400_0100; req_dma.aw_id = 4'd1;
    req_dma.aw_size  = 3'd6; req_dma.aw_burst = 2'b01;
    req_bfm.aw_valid = 1'b1; req_bfm.aw_addr = 32'h1400_0200; req_bfm.aw_id = 4'd2;
    req_bfm.aw_size  = 3'd6; req_bfm.aw_burst = 2'b01;
    rsp_i.aw_ready   = 1'b1;

    @(negedge clk);
    req_bfm.ar_valid = 1'b1; req_bfm.ar_addr = 32'h1400_0100; req_bfm.ar_id = 4'd3;
    #3;
    chk64("tie_dma_first", 64'(wg), 64'h1);
    chk64("aw_addr_dma", 64'(req_o.aw_addr), 64'h1400_0100);
    chk64("bfm_aw_ready_blocked", 64'(rsp_bfm.aw_ready), 64'd0);

    @(negedge clk);
    req_dma.aw_valid = 1'b0;
    req_dma.w_valid = 1'b1; req_dma.w_last = 1'b1; req_dma.w_data = PAT1; req_dma.w_strb = '1;
    rsp_i.w_ready = 1'b1;
    rsp_i.ar_ready = 1'b1;
    #3;
    chk64("rd_grant_bfm_concurrent", 64'(rg), 64'h2);
    chk64("wr_grant_dma_held", 64'(wg), 64'h1);
    chk64("w_data_pat1", 64'(req_o.w_data == PAT1), 64'd1);
    chk64("ar_addr_bfm", 64'(req_o.ar_addr), 64'h1400_0100);

    @(negedge clk);
    req_dma.w_valid = 1'b0; req_dma.b_ready = 1'b1;
    rsp_i.w_ready = 1'b0; rsp_i.b_valid = 1'b1; rsp_i.b_id = 4'd1; rsp_i.b_resp = 2'b00;
    req_bfm.ar_valid = 1'b0; req_bfm.r_ready = 1'b1;
    rsp_i.ar_ready = 1'b0; rsp_i.r_valid = 1'b1; rsp_i.r_last = 1'b1; rsp_i.r_id = 4'd3;
    rsp_i.r_data = PAT2;
    #3;
    chk64("b_valid_dma", 64'(rsp_dma.b_valid), 64'd1);
    chk64("b_valid_bfm", 64'(rsp_bfm.b_valid), 64'd0);
    chk64("b_id_dma", 64'(rsp_dma.b_id), 64'd1);
    chk64("r_data_bfm", 64'(rsp_bfm.r_data == PAT2), 64'd1);
    chk64("r_valid_dma", 64'(rsp_dma.r_valid), 64'd0);

    @(negedge clk);
    rsp_i.b_valid = 1'b0; rsp_i.r_valid = 1'b0; rsp_i.r_last = 1'b0;
    req_dma.b_ready = 1'b0; req_bfm.r_ready = 1'b0;
    #3;
    chk64("gap_wr_idle", 64'(wg), 64'd0);
    chk64("gap_rd_idle", 64'(rg), 64'd0);

    @(negedge clk);
    #3;
    chk64("bfm_granted_next", 64'(wg), 64'h2);
    chk64("aw_addr_bfm", 64'(req_o.aw_addr), 64'h1400_0200);

    // BFM write burst, reset lands on the second W beat.
    @(negedge clk);
    req_bfm.aw_valid = 1'b0;
    req_bfm.w_valid = 1'b1; req_bfm.w_last = 1'b0; req_bfm.w_data = PAT2; req_bfm.w_strb = '1;
    rsp_i.w_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    chk_req("rst_mid_req_o", req_o, '0);
    chk_rsp("rst_mid_resp_bfm", rsp_bfm, '0);
    chk64("rst_mid_wr_grant", 64'(wg), 64'd0);
    chk64("rst_mid_rd_grant", 64'(rg), 64'd0);
    rst = 1'b0;
    req_dma = '0;
    req_bfm = '0;
    rsp_i   = '0;

    // Randomized traffic with occasional reset.
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      rb = rand_bits(); req_dma = rb[$bits(axi_req_t)-1:0];
      rb = rand_bits(); req_bfm = rb[$bits(axi_req_t)-1:0];
      rb = rand_bits(); rsp_i   = rb[$bits(axi_resp_t)-1:0];
    end

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
